// File: rtl/williams_kbd_pkg.sv
// Shared scan codes, output bit positions and the scan-code decoder for
// the Williams keyboard input block.
package williams_kbd_pkg;

    // Player 1 set-2 scan codes
    localparam logic [7:0] SC_P1_UP     = 8'h75;
    localparam logic [7:0] SC_P1_DOWN   = 8'h72;
    localparam logic [7:0] SC_P1_LEFT   = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT  = 8'h74;
    localparam logic [7:0] SC_P1_FIRE_A = 8'h14;
    localparam logic [7:0] SC_P1_FIRE_B = 8'h11;
    localparam logic [7:0] SC_P1_FIRE_C = 8'h29;
    localparam logic [7:0] SC_P1_FIRE_D = 8'h12;

    // Player 2 set-2 scan codes
    localparam logic [7:0] SC_P2_UP     = 8'h2D;
    localparam logic [7:0] SC_P2_DOWN   = 8'h2B;
    localparam logic [7:0] SC_P2_LEFT   = 8'h23;
    localparam logic [7:0] SC_P2_RIGHT  = 8'h34;
    localparam logic [7:0] SC_P2_FIRE_A = 8'h1C;
    localparam logic [7:0] SC_P2_FIRE_B = 8'h1B;
    localparam logic [7:0] SC_P2_FIRE_C = 8'h21;
    localparam logic [7:0] SC_P2_FIRE_D = 8'h1D;

    // System scan codes (F1/1, F2/2, Esc/5 alias onto the same state bit)
    localparam logic [7:0] SC_START1_F  = 8'h05;
    localparam logic [7:0] SC_START1_N  = 8'h16;
    localparam logic [7:0] SC_START2_F  = 8'h06;
    localparam logic [7:0] SC_START2_N  = 8'h1E;
    localparam logic [7:0] SC_COIN1_ESC = 8'h76;
    localparam logic [7:0] SC_COIN1_N   = 8'h2E;
    localparam logic [7:0] SC_COIN2     = 8'h36;

    // btn_p1 / btn_p2 bit positions
    localparam int B_RIGHT  = 0;
    localparam int B_LEFT   = 1;
    localparam int B_DOWN   = 2;
    localparam int B_UP     = 3;
    localparam int B_FIRE_A = 4;
    localparam int B_FIRE_B = 5;
    localparam int B_FIRE_C = 6;
    localparam int B_FIRE_D = 7;

    // btn_sys bit positions
    localparam int S_START1 = 0;
    localparam int S_START2 = 1;
    localparam int S_COIN1  = 2;
    localparam int S_COIN2  = 3;

    typedef enum logic [1:0] {GRP_NONE, GRP_P1, GRP_P2, GRP_SYS} key_grp_e;

    typedef struct packed {
        key_grp_e   grp;
        logic [2:0] idx;
    } key_map_t;

    typedef enum logic {ST_IDLE, ST_HOLD} stretch_st_e;

    // Translate a scan code into the state group and bit it controls.
    // The extended flag is deliberately not an input: arrow keys arrive
    // extended, keypad keys do not, and both drive the same bits.
    function automatic key_map_t map_code(input logic [7:0] code);
        key_map_t m;
        m.grp = GRP_NONE;
        m.idx = 3'd0;
        case (code)
            SC_P1_RIGHT:  begin m.grp = GRP_P1;  m.idx = 3'(B_RIGHT);  end
            SC_P1_LEFT:   begin m.grp = GRP_P1;  m.idx = 3'(B_LEFT);   end
            SC_P1_DOWN:   begin m.grp = GRP_P1;  m.idx = 3'(B_DOWN);   end
            SC_P1_UP:     begin m.grp = GRP_P1;  m.idx = 3'(B_UP);     end
            SC_P1_FIRE_A: begin m.grp = GRP_P1;  m.idx = 3'(B_FIRE_A); end
            SC_P1_FIRE_B: begin m.grp = GRP_P1;  m.idx = 3'(B_FIRE_B); end
            SC_P1_FIRE_C: begin m.grp = GRP_P1;  m.idx = 3'(B_FIRE_C); end
            SC_P1_FIRE_D: begin m.grp = GRP_P1;  m.idx = 3'(B_FIRE_D); end
            SC_P2_RIGHT:  begin m.grp = GRP_P2;  m.idx = 3'(B_RIGHT);  end
            SC_P2_LEFT:   begin m.grp = GRP_P2;  m.idx = 3'(B_LEFT);   end
            SC_P2_DOWN:   begin m.grp = GRP_P2;  m.idx = 3'(B_DOWN);   end
            SC_P2_UP:     begin m.grp = GRP_P2;  m.idx = 3'(B_UP);     end
            SC_P2_FIRE_A: begin m.grp = GRP_P2;  m.idx = 3'(B_FIRE_A); end
            SC_P2_FIRE_B: begin m.grp = GRP_P2;  m.idx = 3'(B_FIRE_B); end
            SC_P2_FIRE_C: begin m.grp = GRP_P2;  m.idx = 3'(B_FIRE_C); end
            SC_P2_FIRE_D: begin m.grp = GRP_P2;  m.idx = 3'(B_FIRE_D); end
            SC_START1_F,
            SC_START1_N:  begin m.grp = GRP_SYS; m.idx = 3'(S_START1); end
            SC_START2_F,
            SC_START2_N:  begin m.grp = GRP_SYS; m.idx = 3'(S_START2); end
            SC_COIN1_ESC,
            SC_COIN1_N:   begin m.grp = GRP_SYS; m.idx = 3'(S_COIN1);  end
            SC_COIN2:     begin m.grp = GRP_SYS; m.idx = 3'(S_COIN2);  end
            default:      begin m.grp = GRP_NONE; m.idx = 3'd0;        end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/williams_pulse_stretch.sv
// Holds an output high for a minimum number of cycles after each trigger,
// so a quick coin tap still lasts long enough for the game to sample it.
module williams_pulse_stretch
    import williams_kbd_pkg::*;
#(
    parameter int               CNT_W      = 24,
    parameter logic [CNT_W-1:0] MIN_CYCLES = CNT_W'(1200000)
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic clr,
    input  logic trig,
    output logic hold
);

    // The trigger cycle itself is the first held cycle, hence the -1.
    localparam logic [CNT_W-1:0] LOAD = MIN_CYCLES - CNT_W'(1);

    stretch_st_e      st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State and counter registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            st  <= ST_IDLE;
            cnt <= '0;
        end else begin
            st  <= st_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Next state: clear wins, a (re-)trigger reloads, otherwise count down
    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        if (clr) begin
            st_nxt  = ST_IDLE;
            cnt_nxt = '0;
        end else if (trig) begin
            st_nxt  = ST_HOLD;
            cnt_nxt = LOAD;
        end else if (st == ST_HOLD) begin
            if (cnt == '0) begin
                st_nxt = ST_IDLE;
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end
    end

    assign hold = (st == ST_HOLD);

endmodule

// File: rtl/williams_kbd_input.sv
// PS/2 keyboard to Williams arcade control mapping.
// Optional coin stretching is enabled by defining WILLIAMS_KBD_COIN_STRETCH_EN.
module williams_kbd_input
    import williams_kbd_pkg::*;
#(
    parameter logic [23:0] COIN_MIN_CYCLES = 24'd1200000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        kbd_clear,
    output logic [7:0]  btn_p1,
    output logic [7:0]  btn_p2,
    output logic [3:0]  btn_sys,
    output logic        key_evt
);

    logic       tog_q;
    logic       armed;
    logic       evt;
    key_map_t   km;
    logic [7:0] p1_q;
    logic [7:0] p2_q;
    logic [3:0] sys_q;
    logic       unused_ext;

    assign unused_ext = ps2_key[8];
    assign km         = map_code(ps2_key[7:0]);
    // armed stays low for the first cycle after reset so the toggle copy
    // can pick up the current strobe level without producing an event.
    assign evt        = armed & (ps2_key[10] ^ tog_q);

    // Toggle strobe copy and post-reset arming
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            tog_q <= ps2_key[10];
            armed <= 1'b1;
        end
    end

    // Key state: clear has priority, otherwise the last event on a bit wins
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            p1_q    <= '0;
            p2_q    <= '0;
            sys_q   <= '0;
            key_evt <= 1'b0;
        end else begin
            key_evt <= evt;
            if (kbd_clear) begin
                p1_q  <= '0;
                p2_q  <= '0;
                sys_q <= '0;
            end else if (evt) begin
                case (km.grp)
                    GRP_P1:  p1_q[km.idx]       <= ps2_key[9];
                    GRP_P2:  p2_q[km.idx]       <= ps2_key[9];
                    GRP_SYS: sys_q[km.idx[1:0]] <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    assign btn_p1 = p1_q;
    assign btn_p2 = p2_q;

`ifdef WILLIAMS_KBD_COIN_STRETCH_EN
    logic [1:0] coin_press;
    logic [1:0] coin_hold;

    for (genvar i = 0; i < 2; i++) begin : g_coin
        assign coin_press[i] = evt & ps2_key[9] & (km.grp == GRP_SYS) &
                               (km.idx == 3'(S_COIN1 + i));

        williams_pulse_stretch #(
            .CNT_W      (24),
            .MIN_CYCLES (COIN_MIN_CYCLES)
        ) u_stretch (
            .clk_sys (clk_sys),
            .reset   (reset),
            .clr     (kbd_clear),
            .trig    (coin_press[i]),
            .hold    (coin_hold[i])
        );
    end

    assign btn_sys = {sys_q[S_COIN2] | coin_hold[1],
                      sys_q[S_COIN1] | coin_hold[0],
                      sys_q[S_START2],
                      sys_q[S_START1]};
`else
    logic [23:0] unused_coin_min;
    assign unused_coin_min = COIN_MIN_CYCLES;
    assign btn_sys         = sys_q;
`endif

endmodule

// File: tb/tb_williams_kbd_input.sv
// Self-checking bench for williams_kbd_input; follows WILLIAMS_KBD_COIN_STRETCH_EN.
module tb_williams_kbd_input;

    localparam int N = 10;

    logic        clk_sys   = 1'b0;
    logic        reset     = 1'b1;
    logic        kbd_clear = 1'b0;
    logic [10:0] ps2_key   = '0;
    logic [7:0]  btn_p1, btn_p2;
    logic [3:0]  btn_sys;
    logic        key_evt;

    williams_kbd_input #(.COIN_MIN_CYCLES(24'd10)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .kbd_clear (kbd_clear),
        .btn_p1    (btn_p1),
        .btn_p2    (btn_p2),
        .btn_sys   (btn_sys),
        .key_evt   (key_evt)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    // Reference model: lookup tables plus per-bit state and coin press times
    logic [7:0] p1_codes [8] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h14, 8'h11, 8'h29, 8'h12};
    logic [7:0] p2_codes [8] = '{8'h34, 8'h23, 8'h2B, 8'h2D, 8'h1C, 8'h1B, 8'h21, 8'h1D};
    logic [7:0] sys_codes[7] = '{8'h05, 8'h16, 8'h06, 8'h1E, 8'h76, 8'h2E, 8'h36};
    int         sys_bits [7] = '{0, 0, 1, 1, 2, 2, 3};

    logic [7:0] m_p1 = '0, m_p2 = '0;
    logic [3:0] m_sys = '0;
    logic       m_evt = 1'b0;
    int         cyc = 0;
    int         press_cyc[2] = '{-1000, -1000};
    logic       pend = 1'b0;
    logic [7:0] pend_code = '0;
    logic       pend_pr = 1'b0;

    function automatic logic [3:0] exp_sys();
        logic [3:0] s;
        s = m_sys;
`ifdef WILLIAMS_KBD_COIN_STRETCH_EN
        for (int c = 0; c < 2; c++)
            if (cyc < press_cyc[c] + N) s[2+c] = 1'b1;
`endif
        return s;
    endfunction

    task automatic model_apply(input logic [7:0] code, input logic pr);
        for (int i = 0; i < 8; i++) begin
            if (code == p1_codes[i]) m_p1[i] = pr;
            if (code == p2_codes[i]) m_p2[i] = pr;
        end
        for (int j = 0; j < 7; j++) begin
            if (code == sys_codes[j]) begin
                m_sys[sys_bits[j]] = pr;
                if (pr && sys_bits[j] >= 2) press_cyc[sys_bits[j]-2] = cyc;
            end
        end
    endtask

    task automatic model_zero();
        m_p1 = '0; m_p2 = '0; m_sys = '0; m_evt = 1'b0;
        press_cyc[0] = -1000; press_cyc[1] = -1000;
    endtask

    task automatic send(input logic [7:0] code, input logic pr);
        ps2_key   = {~ps2_key[10], pr, 1'($urandom_range(0, 1)), code};
        pend      = 1'b1;
        pend_code = code;
        pend_pr   = pr;
    endtask

    // Advance one clock, update the model for that edge, settle past it
    task automatic tick();
        @(posedge clk_sys);
        cyc++;
        m_evt = pend;
        if (kbd_clear) model_zero();
        else if (pend) model_apply(pend_code, pend_pr);
        m_evt = pend;
        pend  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk_sys); #1;
        total++; if (btn_p1 !== 8'h00) begin bad++; $display("FAIL reset_p1: got %h want 00", btn_p1); end
        total++; if (btn_p2 !== 8'h00) begin bad++; $display("FAIL reset_p2: got %h want 00", btn_p2); end
        total++; if (btn_sys !== 4'h0) begin bad++; $display("FAIL reset_sys: got %h want 0", btn_sys); end
        total++; if (key_evt !== 1'b0) begin bad++; $display("FAIL reset_evt: got %b want 0", key_evt); end
        ps2_key = 11'h400;   // strobe high while reset releases
        reset   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (key_evt !== 1'b0) begin bad++; $display("FAIL reset_release_evt: got %b want 0", key_evt); end
        end
    endtask

    task automatic test_p1_up();
        send(8'h75, 1'b1); tick();
        total++; if (btn_p1[3] !== 1'b1) begin bad++; $display("FAIL up_press: got %b want 1", btn_p1[3]); end
        total++; if (key_evt !== 1'b1) begin bad++; $display("FAIL up_evt: got %b want 1", key_evt); end
        tick();
        total++; if (key_evt !== 1'b0) begin bad++; $display("FAIL up_evt_width: got %b want 0", key_evt); end
        send(8'h75, 1'b0); tick();
        total++; if (btn_p1[3] !== 1'b0) begin bad++; $display("FAIL up_release: got %b want 0", btn_p1[3]); end
    endtask

    task automatic test_alias();
        send(8'h05, 1'b1); tick();
        total++; if (btn_sys[0] !== 1'b1) begin bad++; $display("FAIL alias_f1: got %b want 1", btn_sys[0]); end
        send(8'h16, 1'b1); tick();
        send(8'h16, 1'b0); tick();
        total++; if (btn_sys[0] !== 1'b0) begin bad++; $display("FAIL alias_last_wins: got %b want 0", btn_sys[0]); end
        total++; if (btn_sys !== exp_sys()) begin bad++; $display("FAIL alias_sys: got %h want %h", btn_sys, exp_sys()); end
        send(8'h05, 1'b0); tick();
    endtask

    task automatic test_unmapped();
        send(8'h2D, 1'b1); tick();
        send(8'h5A, 1'b1); tick();
        total++; if (key_evt !== 1'b1) begin bad++; $display("FAIL unmapped_evt: got %b want 1", key_evt); end
        total++; if (btn_p2 !== 8'h08) begin bad++; $display("FAIL unmapped_p2: got %h want 08", btn_p2); end
        total++; if (btn_p1 !== m_p1) begin bad++; $display("FAIL unmapped_p1: got %h want %h", btn_p1, m_p1); end
        total++; if (btn_sys !== exp_sys()) begin bad++; $display("FAIL unmapped_sys: got %h want %h", btn_sys, exp_sys()); end
        tick();
        total++; if (key_evt !== 1'b0) begin bad++; $display("FAIL unmapped_evt_width: got %b want 0", key_evt); end
        // identical repeat is idempotent
        send(8'h2D, 1'b1); tick();
        total++; if (btn_p2 !== 8'h08) begin bad++; $display("FAIL repeat_p2: got %h want 08", btn_p2); end
    endtask

    task automatic test_clear();
        send(8'h14, 1'b1);
        kbd_clear = 1'b1;
        tick();
        kbd_clear = 1'b0;
        total++; if (btn_p1 !== 8'h00) begin bad++; $display("FAIL clear_p1: got %h want 00", btn_p1); end
        total++; if (btn_p2 !== 8'h00) begin bad++; $display("FAIL clear_p2: got %h want 00", btn_p2); end
        total++; if (btn_sys !== 4'h0) begin bad++; $display("FAIL clear_sys: got %h want 0", btn_sys); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (key_evt !== 1'b0 || btn_p1 !== 8'h00) begin
                bad++; $display("FAIL clear_consumed: got evt=%b p1=%h want 0/00", key_evt, btn_p1);
            end
        end
    endtask

    task automatic test_coin();
`ifdef WILLIAMS_KBD_COIN_STRETCH_EN
        int hi;
        hi = 0;
        send(8'h76, 1'b1); tick();
        if (btn_sys[2]) hi++;
        for (int k = 1; k < 30; k++) begin
            if (k == 2) send(8'h76, 1'b0);
            tick();
            if (btn_sys[2]) hi++;
            total++; if (btn_sys !== exp_sys()) begin bad++; $display("FAIL coin_trace: got %h want %h", btn_sys, exp_sys()); end
        end
        total++; if (hi !== N) begin bad++; $display("FAIL coin_len: got %0d want %0d", hi, N); end
        hi = 0;
        send(8'h76, 1'b1); tick();
        if (btn_sys[2]) hi++;
        for (int k = 1; k < 30; k++) begin
            if (k == 2) send(8'h76, 1'b0);
            if (k == 5) send(8'h76, 1'b1);
            if (k == 7) send(8'h76, 1'b0);
            tick();
            if (btn_sys[2]) hi++;
        end
        total++; if (hi !== 15) begin bad++; $display("FAIL coin_repress_len: got %0d want 15", hi); end
`else
        send(8'h76, 1'b1); tick();
        total++; if (btn_sys[2] !== 1'b1) begin bad++; $display("FAIL coin1_press: got %b want 1", btn_sys[2]); end
        send(8'h76, 1'b0); tick();
        total++; if (btn_sys[2] !== 1'b0) begin bad++; $display("FAIL coin1_release: got %b want 0", btn_sys[2]); end
        send(8'h36, 1'b1); tick();
        total++; if (btn_sys !== 4'h8) begin bad++; $display("FAIL coin2_press: got %h want 8", btn_sys); end
        send(8'h36, 1'b0); tick();
`endif
    endtask

    task automatic test_random(input int n, input int max_gap);
        logic [7:0] code;
        int         r;
        int         gap;
        for (int e = 0; e < n; e++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      code = p1_codes[$urandom_range(0, 7)];
            else if (r < 6) code = p2_codes[$urandom_range(0, 7)];
            else if (r < 8) code = sys_codes[$urandom_range(0, 6)];
            else            code = 8'($urandom_range(0, 255));
            send(code, 1'($urandom_range(0, 1)));
            kbd_clear = ($urandom_range(0, 15) == 0);
            gap = int'($urandom_range(0, max_gap));
            for (int g = 0; g <= gap; g++) begin
                tick();
                kbd_clear = 1'b0;
                total++; if (btn_p1 !== m_p1) begin bad++; $display("FAIL rnd_p1: got %h want %h", btn_p1, m_p1); end
                total++; if (btn_p2 !== m_p2) begin bad++; $display("FAIL rnd_p2: got %h want %h", btn_p2, m_p2); end
                total++; if (btn_sys !== exp_sys()) begin bad++; $display("FAIL rnd_sys: got %h want %h", btn_sys, exp_sys()); end
                total++; if (key_evt !== m_evt) begin bad++; $display("FAIL rnd_evt: got %b want %b", key_evt, m_evt); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            send(p2_codes[i], 1'b1); tick();
        end
        total++; if (btn_p2 !== 8'hFF) begin bad++; $display("FAIL mid_p2_full: got %h want FF", btn_p2); end
        send(8'h2E, 1'b1); tick();
        send(8'h2E, 1'b0); tick();
        #2;
        reset = 1'b1;
        #1;
        model_zero();
        total++; if (btn_p2 !== 8'h00) begin bad++; $display("FAIL mid_reset_p2: got %h want 00", btn_p2); end
        total++; if (btn_sys !== 4'h0) begin bad++; $display("FAIL mid_reset_sys: got %h want 0", btn_sys); end
        total++; if (btn_p1 !== 8'h00 || key_evt !== 1'b0) begin
            bad++; $display("FAIL mid_reset_p1_evt: got %h/%b want 00/0", btn_p1, key_evt);
        end
        ps2_key[10] = ~ps2_key[10];
        @(posedge clk_sys); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (key_evt !== 1'b0 || btn_sys !== 4'h0) begin
                bad++; $display("FAIL mid_release: got evt=%b sys=%h want 0/0", key_evt, btn_sys);
            end
        end
    endtask

    initial begin
        test_reset();
        test_p1_up();
        test_alias();
        test_unmapped();
        test_clear();
        test_coin();
        test_random(24, 0);     // back-to-back events
        test_random(150, 3);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
